// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The read-back states exist only when ALU_SEQ_VERIFY_EN is defined.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RD,
    S_RR,
    S_RSP
`ifdef ALU_SEQ_VERIFY_EN
    ,
    S_RVA,
    S_RVR
`endif
  } seq_state_t;

  localparam logic [7:0] REG_OPA = 8'h00;
  localparam logic [7:0] REG_OPB = 8'h04;
  localparam logic [7:0] REG_OP  = 8'h08;
  localparam logic [7:0] REG_RES = 8'h0C;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// AXI4-Lite master that writes opA/opB/opcode into the ALU slave, then reads the result back.
// Optional feature macro: ALU_SEQ_VERIFY_EN (read back and compare every written register).
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DATA_W    = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_W-1:0]     cmd_opa,
  input  logic [DATA_W-1:0]     cmd_opb,
  input  logic [DATA_W-1:0]     cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [1:0]            rsp_err,
  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  seq_state_t          r_state, w_next;
  logic [1:0]          r_idx;
  logic                r_alive, r_aw_done, r_w_done, r_err0;
  logic [DATA_W-1:0]   r_opa, r_opb, r_op, r_rsp_data, w_wdata;
  logic [7:0]          w_reg_off;
  logic [ADDR_W-1:0]   w_reg_addr;
  logic                w_last, w_wr_done;
`ifdef ALU_SEQ_VERIFY_EN
  logic                r_err1;
`endif

  always_comb begin
    w_wdata   = r_op;
    w_reg_off = REG_OP;
    case (r_idx)
      2'd0: begin
        w_wdata   = r_opa;
        w_reg_off = REG_OPA;
      end
      2'd1: begin
        w_wdata   = r_opb;
        w_reg_off = REG_OPB;
      end
      default: ;
    endcase
  end

  assign w_last     = (r_idx == 2'd2);
  assign w_reg_addr = BASE_ADDR + ADDR_W'(w_reg_off);
  // AW and W may complete in either order; a done flag remembers the earlier one.
  assign w_wr_done  = (r_aw_done || M_AXI_AWREADY) && (r_w_done || M_AXI_WREADY);

  assign M_AXI_AWADDR = w_reg_addr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = w_wdata;
  assign M_AXI_WSTRB  = {(DATA_W/8){1'b1}};
  assign rsp_valid    = (r_state == S_RSP);
  assign rsp_data     = r_rsp_data;
`ifdef ALU_SEQ_VERIFY_EN
  assign rsp_err      = {r_err1, r_err0};
`else
  assign rsp_err      = {1'b0, r_err0};
`endif

  always_comb begin
    w_next        = r_state;
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    M_AXI_ARADDR  = BASE_ADDR + ADDR_W'(REG_RES);
    case (r_state)
      S_IDLE: begin
        cmd_ready = r_alive;
        if (cmd_valid && r_alive) w_next = S_WR;
      end
      S_WR: begin
        M_AXI_AWVALID = !r_aw_done;
        M_AXI_WVALID  = !r_w_done;
        if (w_wr_done) w_next = S_WB;
      end
      S_WB: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
`ifdef ALU_SEQ_VERIFY_EN
          w_next = S_RVA;
`else
          w_next = w_last ? S_RD : S_WR;
`endif
        end
      end
`ifdef ALU_SEQ_VERIFY_EN
      S_RVA: begin
        M_AXI_ARVALID = 1'b1;
        M_AXI_ARADDR  = w_reg_addr;
        if (M_AXI_ARREADY) w_next = S_RVR;
      end
      S_RVR: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) w_next = w_last ? S_RD : S_WR;
      end
`endif
      S_RD: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_next = S_RR;
      end
      S_RR: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) w_next = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_alive keeps cmd_ready low until the first clock after reset is released.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_next;
      r_alive <= 1'b1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_idx      <= 2'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err0     <= 1'b0;
      r_rsp_data <= '0;
`ifdef ALU_SEQ_VERIFY_EN
      r_err1     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_idx  <= 2'd0;
            r_err0 <= 1'b0;
`ifdef ALU_SEQ_VERIFY_EN
            r_err1 <= 1'b0;
`endif
          end
        end
        S_WR: begin
          if (w_wr_done) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) r_aw_done <= 1'b1;
            if (M_AXI_WVALID && M_AXI_WREADY)   r_w_done  <= 1'b1;
          end
        end
        S_WB: begin
          if (M_AXI_BVALID) begin
            r_err0 <= r_err0 | (M_AXI_BRESP != RESP_OKAY);
`ifndef ALU_SEQ_VERIFY_EN
            if (!w_last) r_idx <= r_idx + 2'd1;
`endif
          end
        end
`ifdef ALU_SEQ_VERIFY_EN
        S_RVR: begin
          if (M_AXI_RVALID) begin
            r_err0 <= r_err0 | (M_AXI_RRESP != RESP_OKAY);
            if (M_AXI_RDATA != w_wdata) r_err1 <= 1'b1;
            if (!w_last) r_idx <= r_idx + 2'd1;
          end
        end
`endif
        S_RR: begin
          if (M_AXI_RVALID) begin
            r_rsp_data <= M_AXI_RDATA;
            r_err0     <= r_err0 | (M_AXI_RRESP != RESP_OKAY);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand words are pure data and need no reset.
  always_ff @(posedge ACLK) begin
    if (cmd_valid && cmd_ready) begin
      r_opa <= cmd_opa;
      r_opb <= cmd_opb;
      r_op  <= cmd_op;
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: AXI4-Lite register-model slave plus a response/transaction scoreboard.
// Build with ALU_SEQ_VERIFY_EN defined to exercise the read-back variant.
module tb_alu_cmd_sequencer;

  localparam logic [31:0] BASE = 32'h4000_0000;
`ifdef ALU_SEQ_VERIFY_EN
  localparam int VERIFY = 1;
`else
  localparam int VERIFY = 0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [31:0] cmd_opa, cmd_opb, cmd_op, rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  alu_cmd_sequencer #(.ADDR_W(32), .BASE_ADDR(BASE), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb), .cmd_op(cmd_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- slave register model ----------------
  logic [31:0] regs [4];
  int          aw_delay = 0;
  int          aw_cnt = 0;
  bit          berr_en = 1'b0, corrupt_en = 1'b0;
  logic [31:0] berr_addr = 32'h0;
  logic        aw_got = 1'b0, w_got = 1'b0, bvalid_s = 1'b0, rvalid_s = 1'b0;
  logic [31:0] aw_addr_l, w_data_l, rdata_s, a_eff, d_eff;
  logic [1:0]  bresp_s;

  assign AWREADY = !aw_got && !bvalid_s && (aw_cnt >= aw_delay);
  assign WREADY  = !w_got && !bvalid_s;
  assign ARREADY = !rvalid_s;
  assign BVALID  = bvalid_s;
  assign BRESP   = bresp_s;
  assign RVALID  = rvalid_s;
  assign RDATA   = rdata_s;
  assign RRESP   = 2'b00;
  assign a_eff   = (AWVALID && AWREADY) ? AWADDR : aw_addr_l;
  assign d_eff   = (WVALID && WREADY) ? WDATA : w_data_l;

  function automatic logic [31:0] slv_read(input logic [31:0] a);
    if (a[3:2] == 2'd3) return (regs[2] == 32'd0) ? regs[0] + regs[1] : regs[0] - regs[1];
    if (corrupt_en && a[3:2] == 2'd0) return 32'hDEAD_0000;
    return regs[a[3:2]];
  endfunction

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0; aw_cnt <= 0;
      bresp_s <= 2'b00;
      for (int k = 0; k < 4; k++) regs[k] <= 32'd0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_got <= 1'b1; aw_addr_l <= AWADDR; aw_cnt <= 0;
      end else if (AWVALID) aw_cnt <= aw_cnt + 1;
      if (WVALID && WREADY) begin
        w_got <= 1'b1; w_data_l <= WDATA;
      end
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
        if (a_eff[3:2] != 2'd3) regs[a_eff[3:2]] <= d_eff;
        bvalid_s <= 1'b1;
        bresp_s  <= (berr_en && a_eff == berr_addr) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end
      if (bvalid_s && BREADY) bvalid_s <= 1'b0;
      if (ARVALID && ARREADY) begin
        rvalid_s <= 1'b1; rdata_s <= slv_read(ARADDR);
      end
      if (rvalid_s && RREADY) rvalid_s <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic [31:0] data; logic [1:0] err; int lat; } exp_t;
  exp_t        sb_q[$];
  logic [31:0] aw_q[$], wd_q[$], ar_q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_fail = 0, acc_cyc = 0;
  int          aw_vcyc = 0, w_vcyc = 0, aw_hs_n = 0;
  bit          rsp_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  always @(negedge ACLK) begin
    if (ARESET) rsp_pend = 1'b0;
    else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (AWVALID) aw_vcyc++;
      if (WVALID) w_vcyc++;
      if (AWVALID && AWREADY) begin
        aw_hs_n++;
        chk("aw_expected", 32'(aw_q.size() != 0), 32'd1);
        if (aw_q.size() != 0) chk("awaddr", AWADDR, aw_q.pop_front());
        chk("awprot", 32'(AWPROT), 32'd0);
      end
      if (WVALID && WREADY) begin
        chk("w_expected", 32'(wd_q.size() != 0), 32'd1);
        if (wd_q.size() != 0) chk("wdata", WDATA, wd_q.pop_front());
        chk("wstrb", 32'(WSTRB), 32'hF);
      end
      if (ARVALID && ARREADY) begin
        chk("ar_expected", 32'(ar_q.size() != 0), 32'd1);
        if (ar_q.size() != 0) chk("araddr", ARADDR, ar_q.pop_front());
        if (ARADDR == BASE + 32'hC) chk("writes_before_result_read", 32'(aw_q.size()), 32'd0);
        chk("arprot", 32'(ARPROT), 32'd0);
      end
      if (rsp_valid && !rsp_pend) begin
        rsp_pend = 1'b1;
        if (sb_q.size() != 0) chk("latency", 32'(cyc - acc_cyc), 32'(sb_q[0].lat));
      end
      if (rsp_valid && rsp_ready) begin
        rsp_pend = 1'b0;
        chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("rsp_data", rsp_data, mon_e.data);
          chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int lat_for(input int awd);
    return 3 * ((1 + awd) + 1 + 2 * VERIFY) + 3;
  endfunction

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op,
                          input logic [1:0] err, input int lat);
    exp_t e;
    e.data = (op == 32'd0) ? a + b : a - b;
    e.err  = err;
    e.lat  = lat;
    sb_q.push_back(e);
    aw_q.push_back(BASE); aw_q.push_back(BASE + 32'd4); aw_q.push_back(BASE + 32'd8);
    wd_q.push_back(a); wd_q.push_back(b); wd_q.push_back(op);
    if (VERIFY != 0) begin
      ar_q.push_back(BASE); ar_q.push_back(BASE + 32'd4); ar_q.push_back(BASE + 32'd8);
    end
    ar_q.push_back(BASE + 32'hC);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op);
    bit ok = 1'b0;
    @(posedge ACLK); #1;
    cmd_valid = 1'b1; cmd_opa = a; cmd_opb = b; cmd_op = op;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    chk("cmd_accept", 32'(ok), 32'd1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge ACLK);
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] op,
                     input logic [1:0] err, input int awd, input string tag);
    aw_delay = awd;
    push_exp(a, b, op, err, lat_for(awd));
    issue(a, b, op);
    wait_done(tag);
  endtask

  int a0, w0, h0;
  bit seen;

  initial begin
    cmd_valid = 1'b0; cmd_opa = '0; cmd_opb = '0; cmd_op = '0; rsp_ready = 1'b1;
    ARESET = 1'b1;
    repeat (10) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_awvalid", 32'(AWVALID), 32'd0);
    chk("rst_wvalid", 32'(WVALID), 32'd0);
    chk("rst_bready", 32'(BREADY), 32'd0);
    chk("rst_arvalid", 32'(ARVALID), 32'd0);
    chk("rst_rready", 32'(RREADY), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("cmd_ready_release_cycle", 32'(cmd_ready), 32'd0);
    @(negedge ACLK);
    chk("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

    // basic add, wrap-around, subtract
    run(32'h0000_0005, 32'h0000_0007, 32'h0, 2'b00, 0, "t2_basic_done");
    run(32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 2'b00, 0, "t2_wrap_done");
    run(32'h0000_000A, 32'h0000_0003, 32'h1, 2'b00, 0, "t2_sub_done");

    // AWREADY held off while WREADY is immediate
    a0 = aw_vcyc; w0 = w_vcyc; h0 = aw_hs_n;
    run(32'h0000_0100, 32'h0000_0023, 32'h0, 2'b00, 2, "t3_done");
    chk("t3_awvalid_cycles", 32'(aw_vcyc - a0), 32'd9);
    chk("t3_wvalid_cycles", 32'(w_vcyc - w0), 32'd3);
    chk("t3_aw_handshakes", 32'(aw_hs_n - h0), 32'd3);

    // slave error on the opB write does not abort the sequence
    berr_en = 1'b1; berr_addr = BASE + 32'd4;
    run(32'h0000_1234, 32'h0000_1111, 32'h0, 2'b01, 0, "t4_done");
    berr_en = 1'b0;

    // back-pressured response, second command waiting
    aw_delay = 0;
    @(posedge ACLK); #1;
    rsp_ready = 1'b0;
    push_exp(32'h20, 32'h22, 32'h0, 2'b00, lat_for(0));
    issue(32'h20, 32'h22, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    chk("t5_rsp_seen", 32'(seen), 32'd1);
    push_exp(32'h3, 32'h4, 32'h0, 2'b00, lat_for(0));
    cmd_opa = 32'h3; cmd_opb = 32'h4; cmd_op = 32'h0; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      chk("t5_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t5_hold_data", rsp_data, 32'h42);
      chk("t5_hold_err", 32'(rsp_err), 32'd0);
      chk("t5_hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge ACLK); #1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (cmd_ready) begin seen = 1'b1; break; end
    end
    chk("t5_second_accept", 32'(seen), 32'd1);
    @(posedge ACLK); #1;
    cmd_valid = 1'b0;
    wait_done("t5_done");

    // reset in the middle of a write
    aw_delay = 10;
    push_exp(32'h55, 32'h66, 32'h0, 2'b00, lat_for(10));
    issue(32'h55, 32'h66, 32'h0);
    @(negedge ACLK);
    chk("mid_awvalid_before_reset", 32'(AWVALID), 32'd1);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    chk("mid_rst_awvalid", 32'(AWVALID), 32'd0);
    chk("mid_rst_wvalid", 32'(WVALID), 32'd0);
    chk("mid_rst_arvalid", 32'(ARVALID), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    sb_q.delete(); aw_q.delete(); wd_q.delete(); ar_q.delete();
    aw_delay = 0;
    run(32'h0000_0009, 32'h0000_0008, 32'h1, 2'b00, 0, "recover_done");

`ifdef ALU_SEQ_VERIFY_EN
    // corrupted read-back of opA
    corrupt_en = 1'b1;
    run(32'h0000_0001, 32'h0000_0002, 32'h0, 2'b10, 0, "t6_done");
    corrupt_en = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
